// File: rtl/div_sequencer_if.sv
// Request/response channels between the execute stage and the divide unit.
// The master side issues DIV/DIVU requests and consumes the quotient/remainder pair.
interface div_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_signed;
  logic [31:0] req_dividend;
  logic [31:0] req_divisor;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_quotient;
  logic [31:0] resp_remainder;

  modport master (
    output req_valid, req_signed, req_dividend, req_divisor, resp_ready,
    input  req_ready, resp_valid, resp_quotient, resp_remainder
  );

  modport slave (
    input  req_valid, req_signed, req_dividend, req_divisor, resp_ready,
    output req_ready, resp_valid, resp_quotient, resp_remainder
  );
endinterface

// File: rtl/div_sequencer.sv
// 32-cycle restoring divider for DIV/DIVU, with sign fix-up and a held response.
// Works on operand magnitudes; signs are reapplied when the last step completes.
module div_sequencer (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  output logic           busy,
  div_sequencer_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  count;
  logic [31:0] part_rem;
  logic [31:0] quo;
  logic [31:0] dvs_mag;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] res_q;
  logic [31:0] res_r;

  logic        req_ready;
  logic        accept;
  logic        dvd_neg;
  logic        dvs_neg;
  logic [31:0] dvd_abs;
  logic [31:0] dvs_abs;
  logic [32:0] shifted;
  logic        step_ok;
  logic [31:0] next_rem;
  logic [31:0] next_quo;
  logic [31:0] fixed_q;
  logic [31:0] fixed_r;

  assign req_ready = (state == IDLE) && !flush && !reset;
  assign accept    = bus.req_valid && req_ready;

  assign dvd_neg = bus.req_signed && bus.req_dividend[31];
  assign dvs_neg = bus.req_signed && bus.req_divisor[31];
  assign dvd_abs = dvd_neg ? (~bus.req_dividend + 32'd1) : bus.req_dividend;
  assign dvs_abs = dvs_neg ? (~bus.req_divisor + 32'd1) : bus.req_divisor;

  // The partial remainder stays below the divisor, so after a successful
  // subtract the low 32 bits hold the whole result.
  always_comb begin
    shifted  = {part_rem, quo[31]};
    step_ok  = shifted >= {1'b0, dvs_mag};
    next_rem = step_ok ? (shifted[31:0] - dvs_mag) : shifted[31:0];
    next_quo = {quo[30:0], step_ok};
    fixed_q  = neg_q ? (~next_quo + 32'd1) : next_quo;
    fixed_r  = neg_r ? (~next_rem + 32'd1) : next_rem;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= 5'd0;
      part_rem <= 32'd0;
      quo      <= 32'd0;
      dvs_mag  <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      res_q    <= 32'd0;
      res_r    <= 32'd0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            count    <= 5'd0;
            part_rem <= 32'd0;
            quo      <= dvd_abs;
            dvs_mag  <= dvs_abs;
            neg_q    <= dvd_neg ^ dvs_neg;
            neg_r    <= dvd_neg;
            if (bus.req_divisor == 32'd0) begin
              state <= DONE;
              res_q <= 32'hFFFF_FFFF;
              res_r <= bus.req_dividend;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          part_rem <= next_rem;
          quo      <= next_quo;
          count    <= count + 5'd1;
          if (count == 5'd31) begin
            state <= DONE;
            res_q <= fixed_q;
            res_r <= fixed_r;
          end
        end
        DONE: begin
          if (bus.resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready      = req_ready;
  assign bus.resp_valid     = (state == DONE);
  assign bus.resp_quotient  = res_q;
  assign bus.resp_remainder = res_r;
  assign busy               = (state != IDLE);

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed cases with literal results
// plus random traffic, all compared every cycle against an arithmetic model.
module tb_div_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  div_sequencer_if bus ();

  div_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic [7:0]  lat;
  } vec_t;

  vec_t vecs [7];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    int          sa;
    int          sb;
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end
    return {q, r};
  endfunction

  // Cycle model: a request occupies the unit for 32 cycles before its result shows.
  bit          m_pending = 1'b0;
  bit          m_valid   = 1'b0;
  int          m_wait    = 0;
  logic [31:0] m_q       = 32'd0;
  logic [31:0] m_r       = 32'd0;
  logic [63:0] m_res     = 64'd0;

  initial begin
    forever begin
      @(negedge clk);
      checkOutput("resp_valid", 32'(bus.resp_valid), 32'(m_valid));
      checkOutput("busy", 32'(busy), 32'(m_pending || m_valid));
      checkOutput("req_ready", 32'(bus.req_ready), 32'(!m_pending && !m_valid && !flush && !reset));
      checkOutput("resp_quotient", bus.resp_quotient, m_q);
      checkOutput("resp_remainder", bus.resp_remainder, m_r);
      if (reset) begin
        m_pending = 1'b0;
        m_valid   = 1'b0;
        m_q       = 32'd0;
        m_r       = 32'd0;
      end else if (flush) begin
        m_pending = 1'b0;
        m_valid   = 1'b0;
      end else if (m_valid) begin
        if (bus.resp_ready) m_valid = 1'b0;
      end else if (m_pending) begin
        m_wait--;
        if (m_wait == 0) begin
          m_pending  = 1'b0;
          m_valid    = 1'b1;
          {m_q, m_r} = m_res;
        end
      end else if (bus.req_valid) begin
        m_res = ref_div(bus.req_signed, bus.req_dividend, bus.req_divisor);
        if (bus.req_divisor == 32'd0) begin
          m_valid    = 1'b1;
          {m_q, m_r} = m_res;
        end else begin
          m_pending = 1'b1;
          m_wait    = 32;
        end
      end
    end
  end

  // Callers start at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic startReq(input logic s, input logic [31:0] a, input logic [31:0] b);
    bit ok;
    ok               = 1'b0;
    bus.req_signed   = s;
    bus.req_dividend = a;
    bus.req_divisor  = b;
    bus.req_valid    = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid    = 1'b0;
    bus.req_signed   = 1'($urandom_range(0, 1));
    bus.req_dividend = $urandom;
    bus.req_divisor  = $urandom;
  endtask

  task automatic waitResp(input int hold, input bit poke, output logic [31:0] q, output logic [31:0] r, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      lat++;
      if (bus.resp_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) checkOutput("resp_timeout", 32'd0, 32'd1);
    q = bus.resp_quotient;
    r = bus.resp_remainder;
    if (hold > 0) begin
      for (int n = 0; n < hold; n++) begin
        @(posedge clk);
        #1;
        bus.req_valid = poke && (n == 0);
      end
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b, input int hold,
                               input bit poke, output logic [31:0] q, output logic [31:0] r, output int lat);
    bus.resp_ready = (hold == 0);
    startReq(s, a, b);
    waitResp(hold, poke, q, r, lat);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'($urandom_range(1, 20));
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: actual timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] q;
    logic [31:0] r;
    logic [63:0] res;
    int          lat;

    bus.req_valid    = 1'b0;
    bus.req_signed   = 1'b0;
    bus.req_dividend = 32'd0;
    bus.req_divisor  = 32'd0;
    bus.resp_ready   = 1'b1;

    vecs[0] = '{1'b0, 32'd100,         32'd7,           32'd14,          32'd2,           8'd33};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFD,   32'hFFFF_FFFF,   8'd33};
    vecs[2] = '{1'b1, 32'd7,           32'hFFFF_FFFE,   32'hFFFF_FFFD,   32'd1,           8'd33};
    vecs[3] = '{1'b1, 32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   32'd0,           8'd33};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF,   32'd1,           32'hFFFF_FFFF,   32'd0,           8'd33};
    vecs[5] = '{1'b0, 32'h0000_1234,   32'd0,           32'hFFFF_FFFF,   32'h0000_1234,   8'd1};
    vecs[6] = '{1'b1, 32'hFFFF_FFF0,   32'd0,           32'hFFFF_FFFF,   32'hFFFF_FFF0,   8'd1};

    res = ref_div(1'b1, 32'hFFFF_FFF9, 32'd2);
    checkOutput("model_pin_neg_q", res[63:32], 32'hFFFF_FFFD);
    checkOutput("model_pin_neg_r", res[31:0], 32'hFFFF_FFFF);
    res = ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("model_pin_ovf_q", res[63:32], 32'h8000_0000);
    res = ref_div(1'b0, 32'd1000, 32'd0);
    checkOutput("model_pin_dz_r", res[31:0], 32'd1000);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("reset_quotient", bus.resp_quotient, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] directed vectors");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].s, vecs[i].a, vecs[i].b, 0, 1'b0, q, r, lat);
      checkOutput($sformatf("vec%0d_q", i), q, vecs[i].q);
      checkOutput($sformatf("vec%0d_r", i), r, vecs[i].r);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    $display("[TB] backpressure");
    applyStimulus(1'b0, 32'd1000, 32'd33, 5, 1'b1, q, r, lat);
    checkOutput("bp_q", q, 32'd30);
    checkOutput("bp_r", r, 32'd10);
    applyStimulus(1'b1, 32'hFFFF_FC18, 32'd33, 0, 1'b0, q, r, lat);
    checkOutput("bp_next_q", q, 32'hFFFF_FFE2);
    checkOutput("bp_next_r", r, 32'hFFFF_FFF6);

    $display("[TB] reset mid-calc");
    startReq(1'b1, 32'd12345, 32'd7);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_cycle_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("rst_cycle_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("after_rst_busy", 32'(busy), 32'd0);
    checkOutput("after_rst_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("after_rst_q", bus.resp_quotient, 32'd0);
    checkOutput("after_rst_r", bus.resp_remainder, 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] flush mid-calc");
    startReq(1'b0, 32'd50, 32'd3);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    applyStimulus(1'b0, 32'd81, 32'd9, 0, 1'b0, q, r, lat);
    checkOutput("flush_next_q", q, 32'd9);
    checkOutput("flush_next_r", r, 32'd0);
    checkOutput("flush_next_latency", 32'(lat), 32'd33);

    $display("[TB] flush with request");
    flush            = 1'b1;
    bus.req_valid    = 1'b1;
    bus.req_signed   = 1'b0;
    bus.req_dividend = 32'd5;
    bus.req_divisor  = 32'd1;
    @(negedge clk);
    checkOutput("flush_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    flush         = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush_no_accept_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] random traffic");
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.resp_ready = 1'($urandom_range(0, 1));
        startReq(1'($urandom_range(0, 1)), pickOperand(), pickOperand());
        repeat ($urandom_range(0, 36)) begin
          @(posedge clk);
          #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
      end else begin
        applyStimulus(1'($urandom_range(0, 1)), pickOperand(), pickOperand(),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)), q, r, lat);
      end
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
